// File: rtl/tick_strobe_gen.sv
// Converts a selected divided-clock bit into single-cycle enables in the fast clock domain,
// with a programmable edge prescaler and a wrapping game-tick counter.
module tick_strobe_gen #(
  parameter int DIV_W = 32,
  parameter int SEL_W = 5,
  parameter int PRE_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] divided_clocks,
  input  logic [SEL_W-1:0] sel,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clear,
  output logic             edge_pulse,
  output logic             game_tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             sel_settling
);

  localparam logic [1:0] SETTLE_CYCLES = 2'd3;

  logic             sync0;
  logic             sync1;
  logic             prev;
  logic [SEL_W-1:0] sel_q;
  logic [1:0]       settle_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_last;
  logic             src_bit;
  logic             raw_edge;
  logic             qual_edge;
  logic             tick_due;

  assign src_bit      = divided_clocks[sel];
  assign raw_edge     = sync1 & ~prev;
  assign sel_settling = (settle_cnt != 2'd0);
  assign qual_edge    = raw_edge & ~sel_settling;

  // A prescale of 0 behaves as 1, so the terminal count is 0 in both cases.
  assign pre_last = (prescale == '0) ? '0 : (prescale - PRE_W'(1));
  assign tick_due = (pre_cnt >= pre_last);

  // Source sampling and the selection-change mask.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      prev       <= 1'b0;
      sel_q      <= sel;
      settle_cnt <= SETTLE_CYCLES;
    end else begin
      sync0 <= src_bit;
      sync1 <= sync0;
      prev  <= sync1;
      sel_q <= sel;
      if (sel != sel_q) begin
        settle_cnt <= SETTLE_CYCLES;
      end else if (settle_cnt != 2'd0) begin
        settle_cnt <= settle_cnt - 2'd1;
      end
    end
  end

  // Strobe output and prescaler; the strobe ignores enable and clear entirely.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      edge_pulse <= 1'b0;
      game_tick  <= 1'b0;
      pre_cnt    <= '0;
      tick_count <= '0;
    end else begin
      edge_pulse <= qual_edge;
      game_tick  <= 1'b0;
      if (clear) begin
        pre_cnt    <= '0;
        tick_count <= '0;
      end else if (qual_edge && enable) begin
        // ">=" lets a lowered prescale fire on the next edge instead of running to wrap.
        if (tick_due) begin
          game_tick  <= 1'b1;
          pre_cnt    <= '0;
          tick_count <= tick_count + CNT_W'(1);
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_strobe_gen.sv
// Self-checking bench for tick_strobe_gen: directed scenarios plus random stimulus,
// all compared against an edge-history reference model.
module tb_tick_strobe_gen;

  localparam int DIV_W = 32;
  localparam int SEL_W = 5;
  localparam int PRE_W = 8;
  // Narrow counter so the wrap boundary is reachable in a short run.
  localparam int CNT_W = 8;
  localparam int MAXE  = 16384;

  logic             clock;
  logic             reset_n;
  logic [DIV_W-1:0] divided_clocks;
  logic [SEL_W-1:0] sel;
  logic             enable;
  logic [PRE_W-1:0] prescale;
  logic             clear;
  logic             edge_pulse;
  logic             game_tick;
  logic [CNT_W-1:0] tick_count;
  logic             sel_settling;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [DIV_W-1:0] div_cnt = '0;

  tick_strobe_gen #(
    .DIV_W(DIV_W), .SEL_W(SEL_W), .PRE_W(PRE_W), .CNT_W(CNT_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .divided_clocks (divided_clocks),
    .sel            (sel),
    .enable         (enable),
    .prescale       (prescale),
    .clear          (clear),
    .edge_pulse     (edge_pulse),
    .game_tick      (game_tick),
    .tick_count     (tick_count),
    .sel_settling   (sel_settling)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running divider: bit i has period 2^(i+1) clocks.
  always @(posedge clock) begin
    div_cnt <= div_cnt + 1;
    cyc     <= cyc + 1;
  end
  assign divided_clocks = div_cnt;

  // Reference model: remembers the selected bit seen at every edge and the edge of
  // the last reset or selection change; outputs follow from those histories.
  bit               samp [MAXE];
  int               edge_no     = 0;
  int               last_change = 0;
  int               since_tick  = 0;
  int               exp_count   = 0;
  logic [SEL_W-1:0] prev_sel    = '0;
  logic             exp_pulse   = 1'b0;
  logic             exp_tick    = 1'b0;
  logic             m_masked, m_raw, m_qual, m_fire;
  int               m_p;

  always_comb begin
    m_masked = ((edge_no - 1 - last_change) < 3);
    m_raw    = (edge_no >= 3) ? (samp[(edge_no - 2) % MAXE] && !samp[(edge_no - 3) % MAXE]) : 1'b0;
    m_qual   = m_raw && !m_masked;
    m_p      = (prescale == '0) ? 1 : int'(prescale);
    m_fire   = m_qual && enable && !clear && ((since_tick + 1) >= m_p);
  end

  always @(posedge clock) begin
    edge_no  <= edge_no + 1;
    prev_sel <= sel;
    if (!reset_n) begin
      samp[edge_no % MAXE] <= 1'b0;
      last_change <= edge_no;
      exp_pulse   <= 1'b0;
      exp_tick    <= 1'b0;
      exp_count   <= 0;
      since_tick  <= 0;
    end else begin
      samp[edge_no % MAXE] <= divided_clocks[sel];
      if (sel != prev_sel) last_change <= edge_no;
      exp_pulse <= m_qual;
      exp_tick  <= m_fire;
      if (clear) begin
        exp_count  <= 0;
        since_tick <= 0;
      end else if (m_qual && enable) begin
        if (m_fire) begin
          exp_count  <= (exp_count + 1) % (1 << CNT_W);
          since_tick <= 0;
        end else begin
          since_tick <= since_tick + 1;
        end
      end
    end
  end

  logic [CNT_W+2:0] dut_vec, exp_vec;
  assign dut_vec = {edge_pulse, game_tick, sel_settling, tick_count};
  assign exp_vec = {exp_pulse, exp_tick, m_masked, exp_count[CNT_W-1:0]};

  always @(negedge clock) begin
    if (reset_n === 1'b1 && game_tick === 1'b1)
      $display("[%0t] game_tick  tick_count=%0d sel=%0d prescale=%0d", $time, tick_count, sel, prescale);
  end

  task automatic test_reset();
    int pulses = 0;
    int ticks  = 0;
    logic want_settle;
    reset_n = 1'b0; sel = '0; enable = 1'b1; prescale = 8'd1; clear = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++;
    if (dut_vec !== {1'b0, 1'b0, 1'b1, {CNT_W{1'b0}}}) begin
      n_fail++; $display("FAIL reset_values got=%h want=%h", dut_vec, {1'b0, 1'b0, 1'b1, {CNT_W{1'b0}}});
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      want_settle = (i <= 2);
      n_checks++;
      if (edge_pulse !== 1'b0 || sel_settling !== want_settle) begin
        n_fail++; $display("FAIL reset_settle i=%0d got pulse=%b settling=%b want pulse=0 settling=%b",
                           i, edge_pulse, sel_settling, want_settle);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      if (edge_pulse === 1'b1) pulses++;
      if (game_tick === 1'b1) ticks++;
    end
    n_checks++;
    if (pulses != 10 || ticks != 10 || tick_count !== CNT_W'(10)) begin
      n_fail++; $display("FAIL toggle_rate got pulses=%0d ticks=%0d count=%0d want 10/10/10", pulses, ticks, tick_count);
    end
  endtask

  task automatic test_period8();
    int last_pulse = -1;
    int last_tick  = -1;
    int pulses = 0;
    int ticks  = 0;
    sel = 5'd2; prescale = 8'd4; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 85; i++) begin
      @(negedge clock);
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL period8_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      if (i >= 5 && edge_pulse === 1'b1) begin
        pulses++;
        n_checks++;
        if (divided_clocks[2:0] !== 3'd7) begin
          n_fail++; $display("FAIL period8_latency got phase=%0d want 7", divided_clocks[2:0]);
        end
        if (last_pulse >= 0) begin
          n_checks++;
          if (i - last_pulse != 8) begin n_fail++; $display("FAIL period8_gap got=%0d want=8", i - last_pulse); end
        end
        last_pulse = i;
      end
      if (i >= 5 && game_tick === 1'b1) begin
        ticks++;
        if (last_tick >= 0) begin
          n_checks++;
          if (i - last_tick != 32) begin n_fail++; $display("FAIL tick_gap got=%0d want=32", i - last_tick); end
        end
        last_tick = i;
      end
    end
    n_checks++;
    if (pulses != 10 || ticks < 2) begin
      n_fail++; $display("FAIL period8_counts got pulses=%0d ticks=%0d want 10 and >=2", pulses, ticks);
    end
  endtask

  task automatic test_prescale_zero();
    logic [39:0] pat [2];
    for (int run = 0; run < 2; run++) begin
      sel = '0; prescale = (run == 0) ? 8'd1 : 8'd0; clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      repeat (5) @(negedge clock);
      for (int k = 0; k < 4 && divided_clocks[0] !== 1'b0; k++) @(negedge clock);
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        n_checks++;
        if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL presc0_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
        pat[run][i] = game_tick;
      end
    end
    n_checks++;
    if (pat[1] !== pat[0] || $countones(pat[0]) != 20) begin
      n_fail++; $display("FAIL prescale_zero got=%h want=%h (20 ticks)", pat[1], pat[0]);
    end
  endtask

  task automatic test_lower_prescale();
    bit want [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int seen = 0;
    prescale = 8'd10; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 40 && seen < 5; i++) begin
      @(negedge clock);
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL lower_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      if (edge_pulse === 1'b1) begin
        seen++;
        if (game_tick !== 1'b0) begin n_fail++; $display("FAIL lower_early got tick=%b want 0", game_tick); end
      end
    end
    n_checks++;
    if (seen != 5) begin n_fail++; $display("FAIL lower_timeout got edges=%0d want=5", seen); end
    prescale = 8'd3;
    seen = 0;
    for (int i = 0; i < 40 && seen < 7; i++) begin
      @(negedge clock);
      if (edge_pulse === 1'b1) begin
        n_checks++;
        if (game_tick !== want[seen]) begin
          n_fail++; $display("FAIL lower_pattern edge=%0d got tick=%b want=%b", seen, game_tick, want[seen]);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 7) begin n_fail++; $display("FAIL lower_timeout2 got edges=%0d want=7", seen); end
  endtask

  task automatic test_sel_change();
    bit found = 1'b0;
    logic want_settle, want_pulse;
    sel = 5'd2; prescale = 8'd1;
    repeat (6) @(negedge clock);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (divided_clocks[3:0] === 4'h8) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL selchg_timeout got none want bit3 high phase"); end
    sel = 5'd3;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clock);
      want_settle = (i <= 3);
      want_pulse  = (i == 19);
      n_checks++;
      if (sel_settling !== want_settle || edge_pulse !== want_pulse) begin
        n_fail++; $display("FAIL sel_change i=%0d got settling=%b pulse=%b want settling=%b pulse=%b",
                           i, sel_settling, edge_pulse, want_settle, want_pulse);
      end
    end
  endtask

  task automatic test_clear_wrap();
    bit found = 1'b0;
    sel = '0; prescale = 8'd1; enable = 1'b1; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      @(negedge clock);
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL fill_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      if (tick_count === {CNT_W{1'b1}}) found = 1'b1;
    end
    n_checks++;
    if (!found || edge_pulse !== 1'b1) begin n_fail++; $display("FAIL fill_top got count=%0d pulse=%b want max and 1", tick_count, edge_pulse); end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({edge_pulse, game_tick, tick_count} !== {1'b1, 1'b0, {CNT_W{1'b0}}}) begin
      n_fail++; $display("FAIL clear_vs_edge got pulse=%b tick=%b count=%0d want 1/0/0", edge_pulse, game_tick, tick_count);
    end
    clear = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      @(negedge clock);
      if (tick_count === {CNT_W{1'b1}}) found = 1'b1;
    end
    repeat (2) @(negedge clock);
    n_checks++;
    if (!found || {edge_pulse, game_tick, tick_count} !== {1'b1, 1'b1, {CNT_W{1'b0}}}) begin
      n_fail++; $display("FAIL wrap got pulse=%b tick=%b count=%0d want 1/1/0", edge_pulse, game_tick, tick_count);
    end
  endtask

  task automatic test_enable_freeze();
    int pulses = 0;
    int ticks  = 0;
    logic [CNT_W-1:0] held;
    enable = 1'b0;
    held = tick_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL freeze_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      if (edge_pulse === 1'b1) pulses++;
      if (game_tick === 1'b1) ticks++;
    end
    n_checks++;
    if (pulses != 5 || ticks != 0 || tick_count !== held) begin
      n_fail++; $display("FAIL enable_freeze got pulses=%0d ticks=%0d count=%0d want 5/0/%0d", pulses, ticks, tick_count, held);
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      @(negedge clock);
      if (reset_n === 1'b1) begin
        n_checks++;
        if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      end
      if ($urandom_range(0, 99) < 3) sel = SEL_W'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 5) prescale = PRE_W'($urandom_range(0, 6));
      enable  = ($urandom_range(0, 9) != 0);
      clear   = ($urandom_range(0, 99) < 3);
      reset_n = ($urandom_range(0, 199) != 0);
    end
    reset_n = 1'b1; clear = 1'b0; enable = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; sel = '0; enable = 1'b1; prescale = 8'd1; clear = 1'b0;
    test_reset();
    test_period8();
    test_prescale_zero();
    test_lower_prescale();
    test_sel_change();
    test_clear_wrap();
    test_enable_freeze();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tick_strobe_gen.md
Name: tick_strobe_gen

Overview:
- Consumer end of the divided-clock bus: turns a selected `divided_clocks` bit into single-cycle enable strobes in the fast `clock` domain.
- Lets game logic run on the 50 MHz `clock` with clean enables, instead of clocking flops from divider bits.
- Adds a programmable prescaler that produces a `game_tick` every N selected-bit rising edges, plus a wrapping tick counter.
- Suppresses spurious edges after reset and after the source selection changes.

Parameters:
- DIV_W, 32, width of the `divided_clocks` input bus
- SEL_W, 5, width of the bit-select input (log2 of DIV_W)
- PRE_W, 8, width of the prescale value
- CNT_W, 16, width of the `game_tick` counter

Ports:
- clock  input  1  system clock; all logic on posedge
- reset_n  input  1  synchronous active-low reset
- divided_clocks  input  DIV_W  divided clock bus from the clock divider
- sel  input  SEL_W  index of the bit used as strobe source
- enable  input  1  1 = prescaler and counter advance; 0 = frozen
- prescale  input  PRE_W  rising edges per `game_tick`; value 0 is treated as 1
- clear  input  1  synchronous clear of prescaler and `tick_count`
- edge_pulse  output  1  one-cycle pulse per rising edge of the selected bit
- game_tick  output  1  one-cycle pulse every effective-prescale edges
- tick_count  output  CNT_W  number of `game_tick` pulses since reset/clear; wraps
- sel_settling  output  1  high while edge detection is masked

Behaviour:
- Interface: one clock, `clock`. Reset `reset_n` is synchronous and active-low, sampled only on posedge `clock`.
- Reset (`reset_n`=0 at a posedge):
  - clears `sync0`, `sync1`, `prev`, `pre_cnt`, `tick_count`, `edge_pulse` and `game_tick`;
  - loads `sel_q` with `sel`;
  - sets `settle_cnt` to 3.
- Reset value of every output:
  - `edge_pulse`=0, `game_tick`=0, `tick_count`=0;
  - `sel_settling`=1 for the 3 cycles after reset release.
- Sampling pipeline, every cycle:
  - `sync0` <= `divided_clocks[sel]`; `sync1` <= `sync0`; `prev` <= `sync1`.
  - Raw edge = `sync1` & ~`prev`.
- Latency: if `sync0` first captures 1 at edge E, raw edge is high after E+1 and `edge_pulse` is registered high for exactly the cycle after edge E+2. That is 3 clocks from first sample to pulse.
- Settling:
  - `sel_q` <= `sel` every cycle.
  - If `sel` != `sel_q`, `settle_cnt` <= 3. Otherwise `settle_cnt` decrements when nonzero.
  - `sel_settling` = (`settle_cnt` != 0).
  - Raw edges are discarded while settling; no pulse and no prescaler effect.
  - Consequence: a `sel` change never produces a spurious `edge_pulse`, even if the new bit is high.
- `edge_pulse` is independent of `enable` and `clear`.
- Prescaler: effective P = (`prescale`==0) ? 1 : `prescale`. On a qualified edge with `enable`=1 and `clear`=0:
  - if `pre_cnt` >= P-1: `game_tick` <= 1, `pre_cnt` <= 0, `tick_count` <= `tick_count`+1 (modulo 2^CNT_W);
  - else `pre_cnt` <= `pre_cnt`+1.
  - `game_tick` is high in the same cycle as the corresponding `edge_pulse`.
- Using >= means that lowering `prescale` mid-count below `pre_cnt`+1 fires on the next qualified edge; it never runs to wrap.
- `enable`=0: `pre_cnt` and `tick_count` hold, `game_tick`=0, `edge_pulse` still pulses.
- `clear`=1: `pre_cnt` <= 0, `tick_count` <= 0, `game_tick` <= 0.
  - `clear` has priority over a simultaneous edge, and that edge is not counted.
- Priority, high to low: `reset_n` low, then `clear`, then the settling mask, then the normal edge path.
- Reset mid-count: all state returns to reset values next cycle. Any pulse in flight is dropped.
- Source bit period below 2 cycles (bit 0 toggles every cycle, period 2): one `edge_pulse` every 2 cycles. Behaviour is defined because the source shares `clock`.

Test Plan:
- Reset release, `sel`=0, bit 0 toggling, `prescale`=1, `enable`=1 -> no pulses while `sel_settling`=1 (3 cycles); then `edge_pulse` and `game_tick` every 2 cycles; `tick_count` increments by 1 per pulse.
- `sel`=2 (period 8), `prescale`=4 -> `edge_pulse` every 8 cycles, `game_tick` every 32 cycles; first pulse exactly 3 cycles after `sync0` first captures 1.
- `prescale`=0 versus `prescale`=1 -> identical `game_tick` streams.
- Mid-count (`pre_cnt`=5, `prescale`=10) change `prescale` to 3 -> `game_tick` on the very next `edge_pulse`, then every 3 edges.
- Change `sel` 2->3 while bit 3 is high -> `sel_settling` high 3 cycles; no `edge_pulse` until the next true rising edge of bit 3.
- `clear` asserted in the same cycle as a qualified edge at `tick_count`=0xFFFF -> `tick_count`=0 and `game_tick`=0. Separately, with no `clear`, a tick at 0xFFFF -> `tick_count` wraps to 0. With `enable`=0 over 5 edges -> counts frozen, `edge_pulse` still 5 pulses.
